// File: rtl/line_pkg.sv
// Shared definitions for the line plotter: coordinate width defaults,
// controller states and a small absolute-difference helper.
package line_pkg;

  localparam int XW_DEF = 11;
  localparam int YW_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PLOT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Distance between two non-negative coordinates, always non-negative.
  function automatic int abs_diff(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/line_plotter.sv
// Bresenham line generator: accepts a pair of endpoints and streams every
// raster point of the line over a valid/ready handshake, one per cycle.
module line_plotter
  import line_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int YW = YW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  output logic          pt_valid,
  input  logic          pt_ready,
  output logic [XW-1:0] pt_x,
  output logic [YW-1:0] pt_y,
  output logic          pt_last,
  output logic          busy,
  output logic          done
);

  // Two extra bits cover the sign plus the doubling of err into e2.
  localparam int W = ((XW > YW) ? XW : YW) + 2;

  state_t               state;
  logic [XW-1:0]        x1_q;
  logic [YW-1:0]        y1_q;
  logic                 sx_neg;
  logic                 sy_neg;
  logic signed [W-1:0]  dx;
  logic signed [W-1:0]  dy;
  logic signed [W-1:0]  err;

  logic signed [W-1:0]  adx;
  logic signed [W-1:0]  ady;
  logic signed [W-1:0]  e2;
  logic signed [W-1:0]  err_next;
  logic                 step_x;
  logic                 step_y;
  logic [XW-1:0]        x_next;
  logic [YW-1:0]        y_next;

  // Endpoint spans, taken from the start point held in pt_x/pt_y during SETUP.
  always_comb begin
    adx = W'(abs_diff(int'(x1_q), int'(pt_x)));
    ady = W'(abs_diff(int'(y1_q), int'(pt_y)));
  end

  // Bresenham step decision; both tests look at the error before this step.
  always_comb begin
    e2       = err <<< 1;
    step_x   = (e2 >= dy);
    step_y   = (e2 <= dx);
    x_next   = pt_x;
    y_next   = pt_y;
    err_next = err + (step_x ? dy : '0) + (step_y ? dx : '0);
    if (step_x) begin
      x_next = sx_neg ? (pt_x - XW'(1)) : (pt_x + XW'(1));
    end
    if (step_y) begin
      y_next = sy_neg ? (pt_y - YW'(1)) : (pt_y + YW'(1));
    end
  end

  // Controller and datapath: latch, set up, emit points, then pulse done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pt_valid <= 1'b0;
      pt_last  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pt_x     <= '0;
      pt_y     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      sx_neg   <= 1'b0;
      sy_neg   <= 1'b0;
      dx       <= '0;
      dy       <= '0;
      err      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            pt_x  <= x0;
            pt_y  <= y0;
            x1_q  <= x1;
            y1_q  <= y1;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          dx       <= adx;
          dy       <= -ady;
          err      <= adx - ady;
          sx_neg   <= !(pt_x < x1_q);
          sy_neg   <= !(pt_y < y1_q);
          pt_last  <= (pt_x == x1_q) && (pt_y == y1_q);
          pt_valid <= 1'b1;
          state    <= PLOT;
        end
        PLOT: begin
          if (pt_ready) begin
            if (pt_last) begin
              pt_valid <= 1'b0;
              pt_last  <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              pt_x    <= x_next;
              pt_y    <= y_next;
              err     <= err_next;
              pt_last <= (x_next == x1_q) && (y_next == y1_q);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          pt_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_plotter.sv
// Self-checking bench for line_plotter: directed corner lines plus random
// lines with random backpressure, compared against a plain integer model.
module tb_line_plotter;

  localparam int XW = 11;
  localparam int YW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [XW-1:0] x0;
  logic [XW-1:0] x1;
  logic [YW-1:0] y0;
  logic [YW-1:0] y1;
  logic          pt_valid;
  logic          pt_ready;
  logic [XW-1:0] pt_x;
  logic [YW-1:0] pt_y;
  logic          pt_last;
  logic          busy;
  logic          done;

  int testCount = 0;
  int failCount = 0;
  int expX[$];
  int expY[$];

  line_plotter #(.XW(XW), .YW(YW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x0       (x0),
    .x1       (x1),
    .y0       (y0),
    .y1       (y1),
    .pt_valid (pt_valid),
    .pt_ready (pt_ready),
    .pt_x     (pt_x),
    .pt_y     (pt_y),
    .pt_last  (pt_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int absInt(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference line: textbook integer Bresenham over the whole line at once.
  task automatic buildRef(input int ax0, input int ay0, input int ax1, input int ay1);
    int cx, cy, ddx, ddy, sx, sy, e, e2;
    expX.delete();
    expY.delete();
    ddx = absInt(ax1 - ax0);
    ddy = -absInt(ay1 - ay0);
    sx  = (ax0 < ax1) ? 1 : -1;
    sy  = (ay0 < ay1) ? 1 : -1;
    e   = ddx + ddy;
    cx  = ax0;
    cy  = ay0;
    forever begin
      expX.push_back(cx);
      expY.push_back(cy);
      if (cx == ax1 && cy == ay1) break;
      e2 = 2 * e;
      if (e2 >= ddy) begin e += ddy; cx += sx; end
      if (e2 <= ddx) begin e += ddx; cy += sy; end
    end
  endtask

  // Draws one line and checks every transferred point, holds, and the done pulse.
  task automatic applyStimulus(input int ax0, input int ay0, input int ax1, input int ay1,
                               input int bpPct, input int stallIdx, input int stallLen,
                               input bit pokeStart);
    int idx, cycles, stallCnt, heldX, heldY, heldL, span;
    bit held, finished, rdy;
    buildRef(ax0, ay0, ax1, ay1);
    span = (absInt(ax1 - ax0) > absInt(ay1 - ay0)) ? absInt(ax1 - ax0) : absInt(ay1 - ay0);
    @(negedge clk);
    x0 = XW'(ax0); y0 = YW'(ay0); x1 = XW'(ax1); y1 = YW'(ay1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("setup_valid", int'(pt_valid), 0);
    checkOutput("setup_busy", int'(busy), 1);
    @(negedge clk);
    checkOutput("first_valid", int'(pt_valid), 1);
    idx = 0; cycles = 0; stallCnt = 0; held = 0; finished = 0;
    heldX = 0; heldY = 0; heldL = 0;
    while (!finished && cycles < 5000) begin
      if (held) begin
        checkOutput("hold_x", int'(pt_x), heldX);
        checkOutput("hold_y", int'(pt_y), heldY);
        checkOutput("hold_last", int'(pt_last), heldL);
      end
      if (pt_valid) begin
        rdy = ($urandom_range(0, 99) >= bpPct);
        if (idx == stallIdx && stallCnt < stallLen) begin
          rdy = 1'b0;
          stallCnt++;
        end
        pt_ready = rdy;
        if (rdy) begin
          if (idx < expX.size()) begin
            checkOutput("pt_x", int'(pt_x), expX[idx]);
            checkOutput("pt_y", int'(pt_y), expY[idx]);
            checkOutput("pt_last", int'(pt_last), int'(idx == expX.size() - 1));
          end
          idx++;
          held = 1'b0;
          if (pt_last) finished = 1'b1;
        end else begin
          held  = 1'b1;
          heldX = int'(pt_x);
          heldY = int'(pt_y);
          heldL = int'(pt_last);
        end
      end else begin
        checkOutput("valid_in_plot", int'(pt_valid), 1);
        finished = 1'b1;
      end
      if (pokeStart && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        x0 = XW'($urandom); y0 = YW'($urandom);
        x1 = XW'($urandom); y1 = YW'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    pt_ready = 1'(($urandom_range(0, 1)));
    if (cycles >= 5000) checkOutput("timeout", 0, 1);
    checkOutput("count", idx, span + 1);
    checkOutput("done_pulse", int'(done), 1);
    checkOutput("done_valid", int'(pt_valid), 0);
    checkOutput("done_busy", int'(busy), 1);
    start = pokeStart;
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_clear", int'(done), 0);
    checkOutput("idle_busy", int'(busy), 0);
    checkOutput("idle_valid", int'(pt_valid), 0);
  endtask

  initial begin
    int rx0, ry0, rx1, ry1;
    reset = 1'b1; start = 1'b0; pt_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", int'(pt_valid), 0);
    checkOutput("rst_last", int'(pt_last), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_x", int'(pt_x), 0);
    checkOutput("rst_y", int'(pt_y), 0);
    reset = 1'b0;

    applyStimulus(0, 0, 3, 0, 0, -1, 0, 1'b0);
    applyStimulus(0, 0, 1, 3, 0, -1, 0, 1'b0);
    applyStimulus(5, 5, 2, 2, 0, -1, 0, 1'b0);
    applyStimulus(2047, 1023, 0, 0, 0, -1, 0, 1'b0);
    applyStimulus(0, 0, 3, 0, 0, 1, 3, 1'b0);
    applyStimulus(7, 9, 7, 9, 0, -1, 0, 1'b1);

    // Reset mid-line with a simultaneous start, then a fresh line.
    @(negedge clk);
    x0 = '0; y0 = '0; x1 = XW'(10); y1 = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    pt_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_reset_x", int'(pt_x), 2);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    checkOutput("mid_rst_valid", int'(pt_valid), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_x", int'(pt_x), 0);
    @(negedge clk);
    checkOutput("rst_prio_busy", int'(busy), 0);
    applyStimulus(6, 2, 13, 4, 0, -1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        rx0 = $urandom_range(0, 2047); rx1 = $urandom_range(0, 2047);
        ry0 = $urandom_range(0, 1023); ry1 = $urandom_range(0, 1023);
      end else begin
        rx0 = $urandom_range(0, 40); rx1 = $urandom_range(0, 40);
        ry0 = $urandom_range(0, 40); ry1 = $urandom_range(0, 40);
      end
      applyStimulus(rx0, ry0, rx1, ry1, $urandom_range(0, 50), -1, 0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/line_plotter.md
LINE_PLOTTER -- requirements
Module: line_plotter

Interface
REQ-001 Parameter XW, default 11, X coordinate width; matches the raster X counter.
REQ-002 Parameter YW, default 10, Y coordinate width; matches the raster Y counter.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to draw a line; honoured only in IDLE.
REQ-006 x0 / x1  input  XW  start / end X coordinate, sampled on the accepted start.
REQ-007 y0 / y1  input  YW  start / end Y coordinate, sampled on the accepted start.
REQ-008 pt_valid  output  1  a point is presented on pt_x/pt_y.
REQ-009 pt_ready  input  1  consumer accepts the point; transfer when pt_valid && pt_ready.
REQ-010 pt_x / pt_y  output  XW / YW  current point coordinates.
REQ-011 pt_last  output  1  presented point equals (x1,y1); qualified by pt_valid.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after the last point transfers.

Function
REQ-014 States SHALL be IDLE, SETUP, PLOT, DONE.
REQ-015 IDLE + start: latch x0,y0,x1,y1 and go to SETUP; start in any other state SHALL be ignored.
REQ-016 SETUP (1 cycle): dx=|x1-x0|, dy=-|y1-y0|, sx=+1 if x0<x1 else -1, sy likewise, err=dx+dy, cur=(x0,y0); go to PLOT.
REQ-017 err, dx, dy and e2 SHALL be signed, width max(XW,YW)+2; no overflow for any legal endpoint pair.
REQ-018 PLOT: pt_valid=1, pt_x/pt_y=cur, pt_last=(cur==(x1,y1)).
REQ-019 On transfer with pt_last=1: go to DONE.
REQ-020 On transfer with pt_last=0: e2=2*err; if e2>=dy then x+=sx, err+=dy; if e2<=dx then y+=sy, err+=dx; both tests use the pre-update err; both updates may apply in the same cycle.
REQ-021 While pt_valid && !pt_ready, pt_x, pt_y, pt_last and internal state SHALL hold.
REQ-022 Throughput: one point per cycle while pt_ready=1; first pt_valid two cycles after the start cycle.
REQ-023 Point count SHALL equal max(|x1-x0|,|y1-y0|)+1; every octant supported.
REQ-024 Degenerate line (x0==x1, y0==y1): exactly one point, with pt_last=1.
REQ-025 DONE: done=1 for one cycle, pt_valid=0, then IDLE; a start in DONE is ignored.
REQ-026 pt_valid SHALL be 0 outside PLOT; pt_x/pt_y values outside PLOT are don't-care but SHALL be deterministic.

Reset
REQ-027 reset SHALL force IDLE, pt_valid=0, pt_last=0, busy=0, done=0, pt_x=0, pt_y=0, at any state including mid-line.
REQ-028 reset has priority over start in the same cycle.
REQ-029 The first start after reset deasserts SHALL be accepted normally.

Structure
REQ-030 Shared package line_pkg SHALL hold the XW/YW defaults, the state enum (IDLE, SETUP, PLOT, DONE) and an abs-difference function.
REQ-031 Single module; no sub-module is needed. Datapath and FSM are in one sequential process plus combinational e2/decision logic.

Verification
REQ-032 Horizontal: (0,0)->(3,0), pt_ready=1 -> (0,0),(1,0),(2,0),(3,0); pt_last on the 4th; done on the next cycle.
REQ-033 Steep: (0,0)->(1,3) -> (0,0),(0,1),(1,2),(1,3).
REQ-034 Reverse diagonal: (5,5)->(2,2) -> (5,5),(4,4),(3,3),(2,2); then max corner (2047,1023)->(0,0) -> 2048 points, no overflow.
REQ-035 Backpressure: (0,0)->(3,0) with pt_ready low for 3 cycles on the 2nd point -> (1,0) held stable; the sequence is unchanged.
REQ-036 Single point (7,9)->(7,9) -> one transfer with pt_last=1, then done; a start pulsed while busy is ignored.
REQ-037 Reset after 2 transfers of (0,0)->(10,0) -> pt_valid=0 and busy=0 on the next cycle; a new start then draws correctly from the new x0.
